prf_3r_2w: RTL

- Parametrised physical register file for the out-of-order core; successor to the single-entry 3-read/2-write flip-flop cell.
- Holds DEPTH entries, each with a data word and a ready bit.
- Serves three combinational read ports (issue/operand fetch) and two synchronous write ports (writeback), plus one allocate port from rename that clears ready bits.

---
 rtl/prf_pkg.sv | 12 +
 rtl/prf_ready_table.sv | 62 ++++++
 rtl/prf_3r_2w.sv | 106 ++++++++++
 3 files changed

// File: rtl/prf_pkg.sv
// Shared types and defaults for the physical register file.
package prf_pkg;

    localparam int PRF_DATA_WIDTH = 32;
    localparam int PRF_DEPTH      = 64;
    localparam int PRF_ADDR_WIDTH = $clog2(PRF_DEPTH);

    typedef logic [PRF_ADDR_WIDTH-1:0] prf_addr_t;

    localparam int ZERO_IDX = 0;

endpackage

// File: rtl/prf_ready_table.sv
// Per-entry ready bits with write-set / alloc-clear priority and a
// registered popcount of the ready vector.
module prf_ready_table
    import prf_pkg::*;
#(
    parameter int DEPTH      = PRF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set1_en_i,
    input  logic [ADDR_WIDTH-1:0] set1_addr_i,
    input  logic                  set2_en_i,
    input  logic [ADDR_WIDTH-1:0] set2_addr_i,
    input  logic                  clr_en_i,
    input  logic [ADDR_WIDTH-1:0] clr_addr_i,
    output logic [DEPTH-1:0]      rdy_o,
    output logic [ADDR_WIDTH:0]   rdy_count_o
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam bit ZR = (ZERO_REG != 0);

    logic [DEPTH-1:0] rdy_q, rdy_d;
    logic [CW-1:0]    count_q, count_d;
    logic             s1, s2, c;
    logic             inc1, inc2, dec;

    always_comb begin
        s1 = set1_en_i && !(ZR && int'(set1_addr_i) == ZERO_IDX);
        // A duplicate address on port 2 is the same transition as port 1
        s2 = set2_en_i && !(ZR && int'(set2_addr_i) == ZERO_IDX)
             && !(s1 && set2_addr_i == set1_addr_i);
        c  = clr_en_i && !(ZR && int'(clr_addr_i) == ZERO_IDX);

        rdy_d = rdy_q;
        if (s1) rdy_d[set1_addr_i] = 1'b1;
        if (s2) rdy_d[set2_addr_i] = 1'b1;
        if (c)  rdy_d[clr_addr_i]  = 1'b0;

        inc1 = s1 && !rdy_q[set1_addr_i] && !(c && clr_addr_i == set1_addr_i);
        inc2 = s2 && !rdy_q[set2_addr_i] && !(c && clr_addr_i == set2_addr_i);
        dec  = c && rdy_q[clr_addr_i];

        count_d = count_q + CW'(inc1) + CW'(inc2) - CW'(dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q   <= '1;
            count_q <= CW'(DEPTH);
        end else begin
            rdy_q   <= rdy_d;
            count_q <= count_d;
        end
    end

    assign rdy_o       = rdy_q;
    assign rdy_count_o = count_q;

endmodule

// File: rtl/prf_3r_2w.sv
// Physical register file: 3 combinational reads, 2 writes, 1 alloc.
// Optional same-cycle write-to-read forwarding: PRF_WRITE_BYPASS_EN.
module prf_3r_2w
    import prf_pkg::*;
#(
    parameter int DATA_WIDTH = PRF_DATA_WIDTH,
    parameter int DEPTH      = PRF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr1_en_i,
    input  logic [ADDR_WIDTH-1:0] wr1_addr_i,
    input  logic [DATA_WIDTH-1:0] wr1_data_i,
    input  logic                  wr2_en_i,
    input  logic [ADDR_WIDTH-1:0] wr2_addr_i,
    input  logic [DATA_WIDTH-1:0] wr2_data_i,
    input  logic                  alloc_en_i,
    input  logic [ADDR_WIDTH-1:0] alloc_addr_i,
    input  logic                  rd1_en_i,
    input  logic [ADDR_WIDTH-1:0] rd1_addr_i,
    output logic [DATA_WIDTH-1:0] rd1_data_o,
    output logic                  rd1_rdy_o,
    input  logic                  rd2_en_i,
    input  logic [ADDR_WIDTH-1:0] rd2_addr_i,
    output logic [DATA_WIDTH-1:0] rd2_data_o,
    output logic                  rd2_rdy_o,
    input  logic                  rd3_en_i,
    input  logic [ADDR_WIDTH-1:0] rd3_addr_i,
    output logic [DATA_WIDTH-1:0] rd3_data_o,
    output logic                  rd3_rdy_o,
    output logic [ADDR_WIDTH:0]   rdy_count_o
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      rdy;
    logic                  wr1_ok, wr2_ok;

    assign wr1_ok = wr1_en_i && !(ZR && int'(wr1_addr_i) == ZERO_IDX);
    assign wr2_ok = wr2_en_i && !(ZR && int'(wr2_addr_i) == ZERO_IDX);

    // Port 1 is applied last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
            if (wr2_ok) data_q[wr2_addr_i] <= wr2_data_i;
            if (wr1_ok) data_q[wr1_addr_i] <= wr1_data_i;
        end
    end

    prf_ready_table #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_rdy (
        .clk         (clk),
        .rst         (rst),
        .set1_en_i   (wr1_en_i),
        .set1_addr_i (wr1_addr_i),
        .set2_en_i   (wr2_en_i),
        .set2_addr_i (wr2_addr_i),
        .clr_en_i    (alloc_en_i),
        .clr_addr_i  (alloc_addr_i),
        .rdy_o       (rdy),
        .rdy_count_o (rdy_count_o)
    );

    // Returns {rdy, data} for one read port
    function automatic logic [DATA_WIDTH:0] rd_port(
        input logic                  en,
        input logic [ADDR_WIDTH-1:0] addr
    );
        logic [DATA_WIDTH-1:0] d;
        logic                  r;
        d = '0;
        r = 1'b0;
        if (en) begin
            if (ZR && int'(addr) == ZERO_IDX) begin
                r = 1'b1;
            end else begin
                d = data_q[addr];
                r = rdy[addr];
`ifdef PRF_WRITE_BYPASS_EN
                if (wr2_ok && wr2_addr_i == addr) begin
                    d = wr2_data_i;
                    r = 1'b1;
                end
                if (wr1_ok && wr1_addr_i == addr) begin
                    d = wr1_data_i;
                    r = 1'b1;
                end
`endif
            end
        end
        return {r, d};
    endfunction

    assign {rd1_rdy_o, rd1_data_o} = rd_port(rd1_en_i, rd1_addr_i);
    assign {rd2_rdy_o, rd2_data_o} = rd_port(rd2_en_i, rd2_addr_i);
    assign {rd3_rdy_o, rd3_data_o} = rd_port(rd3_en_i, rd3_addr_i);

endmodule
